// File: rtl/ps2_rx_ctrl.sv
// rtl/ps2_rx_ctrl.sv - PS/2 device-to-host frame receiver with byte FIFO and error strobes
//
// Purpose:
//   Receives 11-bit PS/2 frames (start 0, 8 data bits LSB first, odd parity,
//   stop 1) from the raw ps2_clk/ps2_data pins, stores good bytes in a small
//   FIFO and reports overflow, parity, framing and timeout errors as a
//   one-cycle strobe.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous active-high reset
//   ps2_clk     raw PS/2 clock pin (asynchronous)
//   ps2_data    raw PS/2 data pin (asynchronous)
//   data_out    FIFO head byte, 0x00 while the FIFO is empty
//   data_valid  FIFO non-empty
//   data_rd     pop FIFO head, ignored while data_valid=0
//   fifo_count  current FIFO occupancy
//   busy        frame FSM not in IDLE
//   err_valid   one-cycle error strobe
//   err_type    00 overflow, 01 parity, 10 framing, 11 timeout

module ps2_rx_ctrl #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic [7:0]                    data_out,
    output logic                          data_valid,
    input  logic                          data_rd,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          err_valid,
    output logic [1:0]                    err_type
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES);

    localparam logic [WD_W-1:0]  WD_MAX    = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] ERR_OVERFLOW = 2'b00;
    localparam logic [1:0] ERR_PARITY   = 2'b01;
    localparam logic [1:0] ERR_FRAMING  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Synchronizers reset to the idle bus level (high) so that releasing
    // reset never manufactures a falling edge on ps2_clk.
    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic fall;

    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             parity_q;
    logic [WD_W-1:0]  wd_q;
    logic             wd_expire;

    logic             stop_fall;
    logic             parity_ok;
    logic             frame_err;
    logic             parity_err;
    logic             push;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop;
    logic             full;
    logic             do_push;
    logic             overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else begin
            clk_s1   <= ps2_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= ps2_data;
            dat_s2   <= dat_s1;
        end
    end

    assign fall = clk_prev & ~clk_s2;

    // A fall in the very cycle the watchdog would expire still counts as
    // activity, so the frame continues.
    assign wd_expire = (state_q != IDLE) && !fall && (wd_q == WD_MAX);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (wd_expire) begin
            state_d = IDLE;
        end else if (fall) begin
            case (state_q)
                IDLE:    if (!dat_s2) state_d = DATA;
                DATA:    if (bit_cnt_q == 3'd7) state_d = PARITY;
                PARITY:  state_d = STOP;
                STOP:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output / event decode
    always_comb begin
        busy       = (state_q != IDLE);
        stop_fall  = (state_q == STOP) && fall;
        parity_ok  = ^{shift_q, parity_q};
        // Framing outranks parity: a missing stop bit is reported as framing
        // regardless of the parity bit.
        frame_err  = stop_fall && !dat_s2;
        parity_err = stop_fall && dat_s2 && !parity_ok;
        push       = stop_fall && dat_s2 && parity_ok;
    end

    // Frame datapath: bit counter, shift register, parity capture, watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            parity_q  <= 1'b0;
            wd_q      <= '0;
        end else begin
            if (wd_expire) begin
                bit_cnt_q <= 3'd0;
                shift_q   <= 8'h00;
            end else if (fall) begin
                case (state_q)
                    IDLE:    bit_cnt_q <= 3'd0;
                    DATA: begin
                        shift_q   <= {dat_s2, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                    end
                    PARITY:  parity_q <= dat_s2;
                    default: ;
                endcase
            end

            if (state_q == IDLE || fall || wd_expire) begin
                wd_q <= '0;
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end
        end
    end

    // FIFO control. A pop in the push cycle frees the slot, so a full FIFO
    // accepts the new byte; a pop on an empty FIFO is ignored.
    always_comb begin
        pop      = data_rd && (count_q != '0);
        full     = (count_q == CNT_FULL);
        do_push  = push && (!full || pop);
        overflow = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= shift_q;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo FIFO_DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_valid = (count_q != '0);
    assign data_out   = data_valid ? mem[rd_ptr_q] : 8'h00;
    assign fifo_count = count_q;

    // Error strobe. The sources are mutually exclusive: framing, parity and
    // overflow all come from the stop-bit fall (overflow only on a good
    // frame), while timeout only fires in a cycle without a fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_type  <= ERR_OVERFLOW;
        end else begin
            err_valid <= overflow | parity_err | frame_err | wd_expire;
            if (frame_err) begin
                err_type <= ERR_FRAMING;
            end else if (parity_err) begin
                err_type <= ERR_PARITY;
            end else if (wd_expire) begin
                err_type <= ERR_TIMEOUT;
            end else if (overflow) begin
                err_type <= ERR_OVERFLOW;
            end
        end
    end

endmodule

// File: doc/ps2_rx_ctrl.md
PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 100000, maximum clk cycles allowed between ps2_clk falling edges inside a frame.
REQ-002 Parameter: FIFO_DEPTH, 4, number of received-byte entries, power of two.
REQ-003 Port: clk  in  1  system clock, all state on rising edge.
REQ-004 Port: rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: ps2_clk  in  1  raw PS/2 clock pin, asynchronous to clk.
REQ-006 Port: ps2_data  in  1  raw PS/2 data pin, asynchronous to clk.
REQ-007 Port: data_out  out  8  byte at FIFO head, valid only while data_valid=1.
REQ-008 Port: data_valid  out  1  FIFO non-empty.
REQ-009 Port: data_rd  in  1  pop FIFO head this cycle, ignored when data_valid=0.
REQ-010 Port: fifo_count  out  log2(FIFO_DEPTH)+1  current occupancy.
REQ-011 Port: busy  out  1  frame FSM not in IDLE.
REQ-012 Port: err_valid  out  1  one-cycle error strobe.
REQ-013 Port: err_type  out  2  error cause, meaningful only with err_valid (00 overflow, 01 parity, 10 framing, 11 timeout).

Function
REQ-014 ps2_clk and ps2_data SHALL each pass through a 2-FF synchronizer; a third register on synced ps2_clk SHALL form a one-cycle fall pulse = prev & ~cur.
REQ-015 FSM states SHALL be IDLE, DATA, PARITY, STOP; all samples of synced ps2_data SHALL be taken only in cycles where fall=1.
REQ-016 IDLE: fall with data=0 -> DATA, bit_cnt=0; fall with data=1 -> stay IDLE, no error.
REQ-017 DATA: each fall shifts data in LSB first into an 8-bit register; after the 8th bit -> PARITY.
REQ-018 PARITY: fall captures parity bit -> STOP.
REQ-019 STOP: on fall, if stop=1 and XOR(byte, parity)=1 (odd parity), byte SHALL be pushed; if stop=0, err_type=10; else if parity bad, err_type=01; FSM returns to IDLE in all cases.
REQ-020 Framing error SHALL take priority over parity error; an errored frame SHALL never be pushed.
REQ-021 Watchdog counter SHALL clear on every fall and in IDLE; in any other state reaching TIMEOUT_CYCLES-1 without a fall SHALL force IDLE, discard partial byte, and strobe err_type=11.
REQ-022 Latency: push occurs at the clock edge ending the cycle in which the stop-bit fall is seen; data_valid=1 and data_out=byte in the next cycle.
REQ-023 FIFO SHALL output the oldest byte first; data_out SHALL be the head entry combinationally.
REQ-024 Push while full and no pop SHALL drop the new byte, leave contents unchanged, and strobe err_type=00.
REQ-025 Push and pop in the same cycle while full SHALL both take effect; count unchanged, no overflow.
REQ-026 Push and data_rd in the same cycle while empty SHALL push only; count becomes 1.
REQ-027 Read and write pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH.
REQ-028 err_valid SHALL be high for exactly one cycle per error; at most one error per cycle.
REQ-029 busy SHALL be 1 exactly when the FSM is not in IDLE.

Reset
REQ-030 While rst=1: FSM=IDLE, bit_cnt=0, watchdog=0, FIFO pointers/count=0, data_valid=0, busy=0, err_valid=0, err_type=00, data_out=0x00.
REQ-031 While rst=1, synchronizer and edge registers SHALL be 1 (idle bus level), so no spurious fall follows deassertion.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no push and no error strobe.

Verification
REQ-033 Frame 0x1C (start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1) -> one cycle after the stop fall: data_valid=1, data_out=0x1C, fifo_count=1, err_valid never high.
REQ-034 Frame 0x1C with parity 1 -> single err_valid with err_type=01, fifo_count stays 0.
REQ-035 Frame 0xF0 with stop=0 -> err_type=10, no push; the next correct 0xF0 frame -> data_out=0xF0.
REQ-036 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYCLES -> err_type=11, busy=0; the following frame 0x5A is received correctly.
REQ-037 Send 5 frames (0x11..0x15) with data_rd=0 -> fifo_count=4 and one err_type=00 on the 5th; four pops return 0x11..0x14 in order, then data_valid=0.
REQ-038 Assert rst after the 6th data bit -> busy=0, data_valid=0, fifo_count=0; after release the next full frame decodes correctly.
